name_rle_encoder: RTL and testbench

- Compression-side stage that turns a stream of 128-bit read names into run-length records {name, count}.
- Each record is 160 bits: name in [159:32], repeat count in [31:0].
- This is exactly the record format the name-expander stage loads and replays `count` times.
- Sits directly upstream of that expander, either through a record FIFO or directly. Consecutive identical names are merged into one record.

---
 rtl/name_rle_encoder.sv | 159 +++++++++++++++
 tb/tb_name_rle_encoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/name_rle_encoder.sv
// rtl/name_rle_encoder.sv - run-length encoder turning a read-name stream into {name, count} records
//
// Merges consecutive identical names into one record; a run that reaches the
// all-ones count is emitted and restarted rather than wrapped.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   in_valid   in_name/in_last valid
//   in_ready   beat accepted when in_valid & in_ready
//   in_name    incoming read name (NAME_W)
//   in_last    final beat of the stream; closes the open run
//   out_valid  out_rec holds a record
//   out_ready  consumer takes the record
//   out_rec    {run_name, run_count}, run_count >= 1

module name_rle_encoder #(
  parameter int NAME_W = 128,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NAME_W-1:0]       in_name,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NAME_W+CNT_W-1:0] out_rec
);

  typedef enum logic [1:0] {ST_EMPTY, ST_RUN, ST_FLUSH} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                    state_q, state_d;
  logic [NAME_W-1:0]         cur_name_q, cur_name_d;
  logic [CNT_W-1:0]          cur_cnt_q, cur_cnt_d;
  logic [NAME_W-1:0]         pend_name_q, pend_name_d;
  logic [NAME_W+CNT_W-1:0]   out_rec_q, out_rec_d;
  logic                      out_valid_q, out_valid_d;

  logic                      slot_free;
  logic                      accept;
  logic                      same_name;
  logic                      cnt_sat;
  logic                      emit;
  logic [NAME_W-1:0]         emit_name;
  logic [CNT_W-1:0]          emit_cnt;

  // Every accepted beat may emit, so input is only taken when the output
  // register is free (or being drained this same cycle).
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q != ST_FLUSH) && slot_free;
  assign accept    = in_valid && in_ready;
  assign same_name = (in_name == cur_name_q);
  assign cnt_sat   = (cur_cnt_q == CNT_MAX);

  assign out_valid = out_valid_q;
  assign out_rec   = out_rec_q;

  always_comb begin
    state_d     = state_q;
    cur_name_d  = cur_name_q;
    cur_cnt_d   = cur_cnt_q;
    pend_name_d = pend_name_q;
    out_rec_d   = out_rec_q;
    out_valid_d = out_valid_q && !out_ready;
    emit        = 1'b0;
    emit_name   = cur_name_q;
    emit_cnt    = cur_cnt_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          if (in_last) begin
            emit      = 1'b1;
            emit_name = in_name;
            emit_cnt  = CNT_ONE;
          end else begin
            cur_name_d = in_name;
            cur_cnt_d  = CNT_ONE;
            state_d    = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (accept) begin
          if (same_name) begin
            if (cnt_sat) begin
              // Saturated run: close it at CNT_MAX and carry the new beat on.
              emit     = 1'b1;
              emit_cnt = CNT_MAX;
              if (in_last) begin
                pend_name_d = in_name;
                state_d     = ST_FLUSH;
              end else begin
                cur_cnt_d = CNT_ONE;
              end
            end else if (in_last) begin
              emit     = 1'b1;
              emit_cnt = cur_cnt_q + CNT_ONE;
              state_d  = ST_EMPTY;
            end else begin
              cur_cnt_d = cur_cnt_q + CNT_ONE;
            end
          end else begin
            emit = 1'b1;
            if (in_last) begin
              // Two records owed; the second waits one cycle in FLUSH.
              pend_name_d = in_name;
              state_d     = ST_FLUSH;
            end else begin
              cur_name_d = in_name;
              cur_cnt_d  = CNT_ONE;
            end
          end
        end
      end

      ST_FLUSH: begin
        if (slot_free) begin
          emit      = 1'b1;
          emit_name = pend_name_q;
          emit_cnt  = CNT_ONE;
          state_d   = ST_EMPTY;
        end
      end

      default: state_d = ST_EMPTY;
    endcase

    if (emit) begin
      out_rec_d   = {emit_name, emit_cnt};
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      cur_name_q  <= '0;
      cur_cnt_q   <= '0;
      pend_name_q <= '0;
      out_rec_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_name_q  <= cur_name_d;
      cur_cnt_q   <= cur_cnt_d;
      pend_name_q <= pend_name_d;
      out_rec_q   <= out_rec_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_name_rle_encoder.sv
// tb/tb_name_rle_encoder.sv - self-checking bench for name_rle_encoder

module tb_name_rle_encoder;

  localparam int NW = 128;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_valid4, in_last, out_ready;
  logic [NW-1:0]  in_name;
  logic           in_ready, in_ready4, out_valid, out_valid4;
  logic [NW+31:0] out_rec;
  logic [NW+3:0]  out_rec4;

  always #5 clk = ~clk;

  name_rle_encoder #(.NAME_W(NW), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_name(in_name), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_rec(out_rec)
  );

  name_rle_encoder #(.NAME_W(NW), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_name(in_name), .in_last(in_last), .out_valid(out_valid4),
    .out_ready(out_ready), .out_rec(out_rec4)
  );

  localparam logic [NW-1:0] NA = {4{32'hA5A5_0001}};
  localparam logic [NW-1:0] NB = {4{32'hB6B6_0002}};
  localparam logic [NW-1:0] NC = {4{32'hC7C7_0003}};
  localparam logic [NW-1:0] ND = {4{32'hD8D8_0004}};
  localparam logic [NW-1:0] NX = {4{32'hEEEE_FFFF}};

  int n_checks = 0;
  int n_pass   = 0;

  logic [NW+31:0] q32[$];
  logic [NW+3:0]  q4[$];
  logic [NW+31:0] exp32;
  logic [NW+3:0]  exp4;

  logic [NW-1:0]  m_name[2];
  int unsigned    m_cnt[2];
  bit             m_open[2];
  longint         beats32 = 0;
  longint         sum32   = 0;

  function automatic void push_rec(bit u4, logic [NW-1:0] n, int unsigned c);
    if (u4) q4.push_back({n, c[3:0]});
    else    q32.push_back({n, c});
  endfunction

  // Reference RLE: open run per DUT, split when the count would exceed its max.
  function automatic void model_beat(bit u4, logic [NW-1:0] n, bit l);
    int idx = u4 ? 1 : 0;
    int unsigned mx = u4 ? 32'd15 : 32'hFFFF_FFFF;
    if (m_open[idx] && n == m_name[idx]) begin
      if (m_cnt[idx] == mx) begin
        push_rec(u4, n, mx);
        m_cnt[idx] = 1;
      end else begin
        m_cnt[idx] = m_cnt[idx] + 1;
      end
    end else begin
      if (m_open[idx]) push_rec(u4, m_name[idx], m_cnt[idx]);
      m_name[idx] = n;
      m_cnt[idx]  = 1;
      m_open[idx] = 1'b1;
    end
    if (l) begin
      push_rec(u4, m_name[idx], m_cnt[idx]);
      m_open[idx] = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    m_open[0] = 1'b0;
    m_open[1] = 1'b0;
    q32.delete();
    q4.delete();
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_checks++;
      if (q32.size() == 0) begin
        $display("FAIL rec32_unexpected actual=%h required=none", out_rec);
      end else begin
        exp32 = q32.pop_front();
        sum32 += out_rec[31:0];
        if (out_rec !== exp32) $display("FAIL rec32 actual=%h required=%h", out_rec, exp32);
        else n_pass++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid4 === 1'b1 && out_ready === 1'b1) begin
      n_checks++;
      if (q4.size() == 0) begin
        $display("FAIL rec4_unexpected actual=%h required=none", out_rec4);
      end else begin
        exp4 = q4.pop_front();
        if (out_rec4 !== exp4) $display("FAIL rec4 actual=%h required=%h", out_rec4, exp4);
        else n_pass++;
      end
      n_checks++;
      if (out_rec4[3:0] === 4'd0) $display("FAIL rec4_zero_count actual=%0d required=nonzero", out_rec4[3:0]);
      else n_pass++;
    end
  end

  // Present one beat and hold it until accepted; the model sees it at the accepting edge.
  task automatic put(input logic [NW-1:0] n, input bit l, input bit u4, output int waits);
    in_name = n;
    in_last = l;
    if (u4) in_valid4 = 1'b1;
    else    in_valid  = 1'b1;
    waits = 0;
    #1;
    while (!(u4 ? in_ready4 : in_ready) && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    n_checks++;
    if (waits >= 50) begin
      $display("FAIL put_timeout actual=%0d required=<50", waits);
    end else begin
      n_pass++;
      @(posedge clk);
      model_beat(u4, n, l);
      if (!u4) beats32++;
      #1;
    end
    in_valid  = 1'b0;
    in_valid4 = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (q32.size() + q4.size() != 0)
      $display("FAIL %s_drain actual=%0d required=0", tag, q32.size() + q4.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_valid4 = 1'b1; in_name = NX; in_last = 1'b1; out_ready = 1'b1;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_rec !== '0)
        $display("FAIL reset_hold actual=%b/%h required=0/0", out_valid, out_rec);
      else n_pass++;
      n_checks++;
      if (out_valid4 !== 1'b0 || out_rec4 !== '0)
        $display("FAIL reset_hold4 actual=%b/%h required=0/0", out_valid4, out_rec4);
      else n_pass++;
    end
    rst = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; in_last = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || out_valid4 !== 1'b0)
        $display("FAIL reset_idle actual=%b%b required=00", out_valid, out_valid4);
      else n_pass++;
    end
  endtask

  task automatic test_runs();
    int w, tot;
    logic [NW-1:0] names[5];
    names = '{NA, NA, NA, NB, NB};
    tot = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      put(names[i], i == 4, 1'b0, w);
      tot += w;
      if (i == 3 || i == 4) begin
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL runs_latency beat=%0d actual=%b required=1", i, out_valid);
        else n_pass++;
      end
    end
    n_checks++;
    if (tot != 0) $display("FAIL runs_in_ready_stalls actual=%0d required=0", tot);
    else n_pass++;
    drain("runs");
  endtask

  task automatic test_last_new();
    int w;
    out_ready = 1'b1;
    put(NA, 1'b0, 1'b0, w);
    put(NA, 1'b0, 1'b0, w);
    put(NC, 1'b1, 1'b0, w);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL flush_ready_low actual=%b required=0", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL flush_ready_back actual=%b required=1", in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b1 || out_rec !== {NC, 32'd1})
      $display("FAIL flush_second_rec actual=%b/%h required=1/%h", out_valid, out_rec, {NC, 32'd1});
    else n_pass++;
    drain("last_new");
  endtask

  task automatic test_saturation();
    int w;
    out_ready = 1'b1;
    for (int i = 1; i <= 17; i++) put(NA, i == 17, 1'b1, w);
    drain("saturation");
  endtask

  task automatic test_backpressure();
    int w;
    out_ready = 1'b1;
    put(NA, 1'b0, 1'b0, w);
    put(NB, 1'b0, 1'b0, w);
    out_ready = 1'b0;
    in_valid = 1'b1; in_name = NC; in_last = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL bp_in_ready actual=%b required=0", in_ready);
      else n_pass++;
      n_checks++;
      if (out_valid !== 1'b1 || out_rec !== {NA, 32'd1})
        $display("FAIL bp_hold actual=%b/%h required=1/%h", out_valid, out_rec, {NA, 32'd1});
      else n_pass++;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    put(NC, 1'b1, 1'b0, w);
    drain("backpressure");
  endtask

  task automatic test_midreset();
    int w;
    out_ready = 1'b1;
    put(NA, 1'b0, 1'b0, w);
    put(NA, 1'b0, 1'b0, w);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_rec !== '0)
      $display("FAIL midreset_clear actual=%b/%h required=0/0", out_valid, out_rec);
    else n_pass++;
    put(ND, 1'b1, 1'b0, w);
    n_checks++;
    if (out_valid !== 1'b1 || out_rec !== {ND, 32'd1})
      $display("FAIL midreset_rec actual=%b/%h required=1/%h", out_valid, out_rec, {ND, 32'd1});
    else n_pass++;
    drain("midreset");
  endtask

  task automatic test_back_to_back();
    int w, tot;
    logic [NW-1:0] pool[3];
    pool = '{NA, NB, NC};
    tot = 0;
    sum32 = 0;
    beats32 = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      put(pool[$urandom_range(0, 2)], i == 23, 1'b0, w);
      tot += w;
    end
    n_checks++;
    if (tot != 0) $display("FAIL b2b_stalls actual=%0d required=0", tot);
    else n_pass++;
    drain("b2b");
    n_checks++;
    if (sum32 != beats32) $display("FAIL b2b_conservation actual=%0d required=%0d", sum32, beats32);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_runs();
    test_last_new();
    test_saturation();
    test_backpressure();
    test_midreset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
